// File: rtl/sha256_pkg.sv
// Shared types for the SHA-256 block: message-memory word width, loader
// state encoding and the read-response beat carried through the latency pipe.
package sha256_pkg;

    localparam int MEM_WORD_W = 32;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
        LD_READY
    } ld_state_t;

    typedef struct packed {
        logic                  vld;
        logic [MEM_WORD_W-1:0] data;
    } mem_resp_t;

endpackage

// File: rtl/sha_mem_ram.sv
// Simple dual-port RAM, one write and one read port, registered read.
// A read and a write to the same word on the same edge return the old word.
module sha_mem_ram #(
    parameter int DEPTH = 256,
    parameter int W     = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_axi,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [W-1:0]  rd
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk_axi) begin
        if (we)
            mem[wa] <= wd;
        if (re)
            rd <= mem[ra];
    end

endmodule

// File: rtl/sha_mem_responder.sv
// Message memory answering the SHA core's read requests at a fixed latency,
// with a valid/ready loader port gated by a small load-state FSM.
module sha_mem_responder
    import sha256_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int RD_LATENCY  = 2,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk_axi,
    input  logic                  rst,
    input  logic                  mem_addr_vld,
    input  logic [31:0]           mem_addr,
    output logic                  mem_data_vld,
    output logic [MEM_WORD_W-1:0] mem_data,
    input  logic                  wr_vld,
    output logic                  wr_rdy,
    input  logic [AW-1:0]         wr_addr,
    input  logic [MEM_WORD_W-1:0] wr_data,
    input  logic                  wr_last,
    input  logic                  clear,
    output logic                  loaded,
    output logic [AW:0]           word_count,
    output logic                  rd_err,
    output logic                  wr_err
);

    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH_WORDS);

    ld_state_t             state;
    logic                  wr_acc;
    logic                  addr_bad;
    logic                  req_vld_q;
    logic                  bad_q;
    logic [MEM_WORD_W-1:0] ram_rdata;
    mem_resp_t             s0;
    mem_resp_t             pipe_q [RD_LATENCY];

    assign wr_acc   = wr_vld && wr_rdy;
    assign addr_bad = (mem_addr[1:0] != 2'b00) || (mem_addr[31:AW+2] != '0);

    sha_mem_ram #(
        .DEPTH (DEPTH_WORDS),
        .W     (MEM_WORD_W),
        .AW    (AW)
    ) u_ram (
        .clk_axi (clk_axi),
        .we      (wr_acc),
        .wa      (wr_addr),
        .wd      (wr_data),
        .re      (mem_addr_vld),
        .ra      (mem_addr[AW+1:2]),
        .rd      (ram_rdata)
    );

    always_ff @(posedge clk_axi) begin
        if (rst) begin
            state      <= LD_IDLE;
            wr_rdy     <= 1'b0;
            loaded     <= 1'b0;
            word_count <= '0;
            wr_err     <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            case (state)
                LD_IDLE, LD_LOAD: begin
                    wr_rdy <= 1'b1;
                    if (wr_acc) begin
                        if (wr_last) begin
                            state  <= LD_READY;
                            wr_rdy <= 1'b0;
                            loaded <= 1'b1;
                        end else begin
                            state  <= LD_LOAD;
                        end
                    end
                end
                LD_READY: begin
                    if (clear) begin
                        state      <= LD_IDLE;
                        wr_rdy     <= 1'b1;
                        loaded     <= 1'b0;
                        word_count <= '0;
                    end
                end
                default: state <= LD_IDLE;
            endcase
            // Writes are never accepted in READY, so this cannot race the clear.
            if (wr_acc && word_count != CNT_MAX)
                word_count <= word_count + (AW+1)'(1);
            if (wr_vld && !wr_rdy)
                wr_err <= 1'b1;
            if (mem_addr_vld && (addr_bad || state != LD_READY))
                rd_err <= 1'b1;
        end
    end

    // Stage 0 is the RAM output register; the request tag travels beside it.
    assign s0.vld  = req_vld_q;
    assign s0.data = bad_q ? '0 : ram_rdata;

    always_ff @(posedge clk_axi) begin
        if (rst) begin
            req_vld_q <= 1'b0;
            bad_q     <= 1'b0;
            for (int k = 0; k < RD_LATENCY; k++)
                pipe_q[k] <= '0;
        end else begin
            req_vld_q <= mem_addr_vld;
            if (mem_addr_vld)
                bad_q <= addr_bad;
            pipe_q[0].vld <= s0.vld;
            if (s0.vld)
                pipe_q[0].data <= s0.data;
            // Data only advances with a valid beat so the output holds between responses.
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe_q[k].vld <= pipe_q[k-1].vld;
                if (pipe_q[k-1].vld)
                    pipe_q[k].data <= pipe_q[k-1].data;
            end
        end
    end

    assign mem_data_vld = pipe_q[RD_LATENCY-1].vld;
    assign mem_data     = pipe_q[RD_LATENCY-1].data;

endmodule

// File: tb/tb_sha_mem_responder.sv
// Directed bench: three responders (latency 2, 1, 4) share one stimulus stream.
module tb_sha_mem_responder;

    logic        clk_axi = 1'b0;
    logic        rst = 1'b1;
    logic        mem_addr_vld = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        wr_vld = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        wr_last = 1'b0;
    logic        clear = 1'b0;

    logic        dvld [3];
    logic [31:0] ddat [3];
    logic        wrdy [3];
    logic        ldd  [3];
    logic [8:0]  wcnt [3];
    logic        rerr [3];
    logic        werr [3];

    int LAT [3] = '{2, 1, 4};
    int checks = 0;
    int errors = 0;

    always #5 clk_axi = ~clk_axi;

    sha_mem_responder #(.DEPTH_WORDS(256), .RD_LATENCY(2)) u_l2 (
        .clk_axi(clk_axi), .rst(rst), .mem_addr_vld(mem_addr_vld), .mem_addr(mem_addr),
        .mem_data_vld(dvld[0]), .mem_data(ddat[0]), .wr_vld(wr_vld), .wr_rdy(wrdy[0]),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last), .clear(clear),
        .loaded(ldd[0]), .word_count(wcnt[0]), .rd_err(rerr[0]), .wr_err(werr[0]));

    sha_mem_responder #(.DEPTH_WORDS(256), .RD_LATENCY(1)) u_l1 (
        .clk_axi(clk_axi), .rst(rst), .mem_addr_vld(mem_addr_vld), .mem_addr(mem_addr),
        .mem_data_vld(dvld[1]), .mem_data(ddat[1]), .wr_vld(wr_vld), .wr_rdy(wrdy[1]),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last), .clear(clear),
        .loaded(ldd[1]), .word_count(wcnt[1]), .rd_err(rerr[1]), .wr_err(werr[1]));

    sha_mem_responder #(.DEPTH_WORDS(256), .RD_LATENCY(4)) u_l4 (
        .clk_axi(clk_axi), .rst(rst), .mem_addr_vld(mem_addr_vld), .mem_addr(mem_addr),
        .mem_data_vld(dvld[2]), .mem_data(ddat[2]), .wr_vld(wr_vld), .wr_rdy(wrdy[2]),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last), .clear(clear),
        .loaded(ldd[2]), .word_count(wcnt[2]), .rd_err(rerr[2]), .wr_err(werr[2]));

    task automatic tick;
        @(posedge clk_axi);
        #1;
    endtask

    // Single request, then wait until the latency-2 instance presents its response.
    task automatic do_read(input logic [31:0] a);
        mem_addr_vld = 1'b1;
        mem_addr     = a;
        tick();
        mem_addr_vld = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({dvld[d], ddat[d], wrdy[d], ldd[d], wcnt[d], rerr[d], werr[d]} !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d: vld=%b data=%h rdy=%b loaded=%b cnt=%0d rd_err=%b wr_err=%b, all required 0",
                         d, dvld[d], ddat[d], wrdy[d], ldd[d], wcnt[d], rerr[d], werr[d]);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (wrdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL idle_wr_rdy: got %b, required 1", wrdy[0]);
        end
    endtask

    task automatic test_load_read;
        for (int i = 0; i < 16; i++) begin
            wr_vld  = 1'b1;
            wr_addr = 8'(i);
            wr_data = 32'h4141_4100 + 32'(i);
            wr_last = (i == 15);
            tick();
        end
        wr_vld  = 1'b0;
        wr_last = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ldd[d] !== 1'b1 || wcnt[d] !== 9'd16 || wrdy[d] !== 1'b0) begin
                errors++;
                $display("FAIL load_done dut%0d: loaded=%b cnt=%0d rdy=%b, required 1/16/0",
                         d, ldd[d], wcnt[d], wrdy[d]);
            end
        end
        for (int t = 0; t < 22; t++) begin
            mem_addr_vld = (t < 16);
            mem_addr     = 32'(t * 4);
            tick();
            for (int d = 0; d < 3; d++) begin
                int  r;
                logic ev;
                r  = t - LAT[d];
                ev = (r >= 0 && r < 16);
                checks++;
                if (dvld[d] !== ev) begin
                    errors++;
                    $display("FAIL stream_vld lat%0d t=%0d: got %b, required %b", LAT[d], t, dvld[d], ev);
                end else if (ev && ddat[d] !== 32'h4141_4100 + 32'(r)) begin
                    errors++;
                    $display("FAIL stream_data lat%0d t=%0d: got %h, required %h",
                             LAT[d], t, ddat[d], 32'h4141_4100 + 32'(r));
                end
            end
        end
        mem_addr_vld = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ddat[d] !== 32'h4141_410F || rerr[d] !== 1'b0) begin
                errors++;
                $display("FAIL stream_hold dut%0d: data=%h rd_err=%b, required 4141410f/0", d, ddat[d], rerr[d]);
            end
        end
    endtask

    task automatic test_bad_addr;
        logic [31:0] addrs [2];
        addrs = '{32'h0000_0002, 32'h0000_0400};
        for (int t = 0; t < 4; t++) begin
            mem_addr_vld = (t < 2);
            mem_addr     = (t < 2) ? addrs[t] : 32'h0;
            tick();
            if (t >= 2) begin
                checks++;
                if (dvld[0] !== 1'b1 || ddat[0] !== 32'h0) begin
                    errors++;
                    $display("FAIL bad_addr_resp t=%0d: vld=%b data=%h, required 1/00000000", t, dvld[0], ddat[0]);
                end
            end
        end
        mem_addr_vld = 1'b0;
        checks++;
        if (rerr[0] !== 1'b1) begin
            errors++;
            $display("FAIL bad_addr_rd_err: got %b, required 1", rerr[0]);
        end
    endtask

    task automatic test_wr_while_ready;
        wr_vld  = 1'b1;
        wr_addr = 8'd5;
        wr_data = 32'h1234_5678;
        tick();
        wr_vld = 1'b0;
        checks++;
        if (werr[0] !== 1'b1 || wcnt[0] !== 9'd16) begin
            errors++;
            $display("FAIL wr_ready_err: wr_err=%b cnt=%0d, required 1/16", werr[0], wcnt[0]);
        end
        do_read(32'h14);
        checks++;
        if (dvld[0] !== 1'b1 || ddat[0] !== 32'h4141_4105) begin
            errors++;
            $display("FAIL wr_ready_ram: vld=%b data=%h, required 1/41414105", dvld[0], ddat[0]);
        end
    endtask

    task automatic test_clear_collision;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (ldd[0] !== 1'b0 || wcnt[0] !== 9'd0 || wrdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL clear: loaded=%b cnt=%0d rdy=%b, required 0/0/1", ldd[0], wcnt[0], wrdy[0]);
        end
        wr_vld       = 1'b1;
        wr_addr      = 8'd5;
        wr_data      = 32'hDEAD_BEEF;
        mem_addr_vld = 1'b1;
        mem_addr     = 32'h14;
        tick();
        wr_vld = 1'b0;
        tick();
        mem_addr_vld = 1'b0;
        tick();
        checks++;
        if (dvld[0] !== 1'b1 || ddat[0] !== 32'h4141_4105) begin
            errors++;
            $display("FAIL collision_old: vld=%b data=%h, required 1/41414105", dvld[0], ddat[0]);
        end
        tick();
        checks++;
        if (dvld[0] !== 1'b1 || ddat[0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL collision_new: vld=%b data=%h, required 1/deadbeef", dvld[0], ddat[0]);
        end
        checks++;
        if (wcnt[0] !== 9'd1 || rerr[0] !== 1'b1) begin
            errors++;
            $display("FAIL collision_state: cnt=%0d rd_err=%b, required 1/1", wcnt[0], rerr[0]);
        end
    endtask

    task automatic test_reset_mid;
        mem_addr_vld = 1'b1;
        mem_addr     = 32'h0;
        tick();
        mem_addr_vld = 1'b0;
        rst          = 1'b1;
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({dvld[d], ddat[d], wrdy[d], ldd[d], wcnt[d], rerr[d], werr[d]} !== '0) begin
                errors++;
                $display("FAIL mid_reset dut%0d: vld=%b data=%h rdy=%b loaded=%b cnt=%0d rd_err=%b wr_err=%b, all required 0",
                         d, dvld[d], ddat[d], wrdy[d], ldd[d], wcnt[d], rerr[d], werr[d]);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (dvld[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL flushed lat%0d c=%0d: vld=%b, required 0", LAT[d], c, dvld[d]);
                end
            end
        end
        wr_vld  = 1'b1;
        wr_addr = 8'd15;
        wr_data = 32'h4141_410F;
        wr_last = 1'b1;
        tick();
        wr_vld  = 1'b0;
        wr_last = 1'b0;
        checks++;
        if (ldd[0] !== 1'b1 || wcnt[0] !== 9'd1) begin
            errors++;
            $display("FAIL reload: loaded=%b cnt=%0d, required 1/1", ldd[0], wcnt[0]);
        end
        do_read(32'hC);
        checks++;
        if (dvld[0] !== 1'b1 || ddat[0] !== 32'h4141_4103 || rerr[0] !== 1'b0) begin
            errors++;
            $display("FAIL ram_retained: vld=%b data=%h rd_err=%b, required 1/41414103/0", dvld[0], ddat[0], rerr[0]);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        do_read(32'h0);
        checks++;
        if (dvld[0] !== 1'b1 || ddat[0] !== 32'h4141_4100 || rerr[0] !== 1'b1) begin
            errors++;
            $display("FAIL early_read: vld=%b data=%h rd_err=%b, required 1/41414100/1", dvld[0], ddat[0], rerr[0]);
        end
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 257; i++) begin
            wr_vld  = 1'b1;
            wr_addr = 8'(i);
            wr_data = 32'(i);
            tick();
        end
        wr_vld = 1'b0;
        checks++;
        if (wcnt[0] !== 9'd256 || wrdy[0] !== 1'b1 || ldd[0] !== 1'b0) begin
            errors++;
            $display("FAIL saturate: cnt=%0d rdy=%b loaded=%b, required 256/1/0", wcnt[0], wrdy[0], ldd[0]);
        end
        wr_vld  = 1'b1;
        wr_last = 1'b1;
        tick();
        wr_vld  = 1'b0;
        wr_last = 1'b0;
        checks++;
        if (wcnt[0] !== 9'd256 || ldd[0] !== 1'b1 || werr[0] !== 1'b0) begin
            errors++;
            $display("FAIL saturate_last: cnt=%0d loaded=%b wr_err=%b, required 256/1/0", wcnt[0], ldd[0], werr[0]);
        end
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_bad_addr();
        test_wr_while_ready();
        test_clear_collision();
        test_reset_mid();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1);
    end

endmodule
